dcache_direct_wb: RTL and testbench



---
 rtl/dcache_direct_wb_if.sv | 26 ++
 rtl/dcache_direct_wb.sv | 159 +++++++++++++++
 tb/tb_dcache_direct_wb.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_direct_wb_if.sv
// Bus bundle between the MEM-stage port, the data cache and main memory.
// The cache is the slave on the processor side and drives the block memory side.
interface dcache_direct_wb_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
    output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
    input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines and a
// 128-bit block memory interface; misses write back a dirty victim before filling.
//
// state       | meaning
// S_IDLE      | compare: hits serviced combinationally, misses start here
// S_WRITEBACK | dirty victim line being written to memory
// S_ALLOCATE  | requested block being read from memory into the line
module dcache_direct_wb #(
  parameter int INDEX_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  dcache_direct_wb_if.slave bus
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 28 - INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [127:0]     r_data [LINES];

  // Block address of the miss in flight, so a dropped request still fills consistently.
  logic [27:0]      r_miss_blk;

  logic               w_req;
  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [1:0]         w_off;
  logic               w_hit;
  logic               w_idle_hit;
  logic               w_idle_miss;
  logic [127:0]       w_line;
  logic [31:0]        w_word;
  logic [INDEX_W-1:0] w_miss_idx;

  assign w_req       = bus.proc_read | bus.proc_write;
  assign w_off       = bus.proc_addr[1:0];
  assign w_idx       = bus.proc_addr[INDEX_W+1:2];
  assign w_tag       = bus.proc_addr[29:INDEX_W+2];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_idle_hit  = (r_state == S_IDLE) && w_req && w_hit;
  assign w_idle_miss = (r_state == S_IDLE) && w_req && !w_hit;
  assign w_line      = r_data[w_idx];
  assign w_word      = w_line[{w_off, 5'd0} +: 32];
  assign w_miss_idx  = r_miss_blk[INDEX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_idle_miss) begin
          w_next_state = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        if (bus.mem_ready) w_next_state = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        if (bus.mem_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.proc_stall = 1'b0;
    bus.proc_rdata = 32'd0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = 28'd0;
    bus.mem_wdata  = 128'd0;
    case (r_state)
      S_IDLE: begin
        if (w_idle_hit) begin
          if (bus.proc_read) bus.proc_rdata = w_word;
        end else if (w_idle_miss && rst_n) begin
          bus.proc_stall = 1'b1;
        end
      end
      S_WRITEBACK: begin
        bus.proc_stall = 1'b1;
        bus.mem_write  = 1'b1;
        bus.mem_addr   = {r_tag[w_miss_idx], w_miss_idx};
        bus.mem_wdata  = r_data[w_miss_idx];
      end
      S_ALLOCATE: begin
        bus.proc_stall = 1'b1;
        bus.mem_read   = 1'b1;
        bus.mem_addr   = r_miss_blk;
      end
      default: begin
        bus.proc_stall = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_blk <= 28'd0;
    end else if (w_idle_miss) begin
      r_miss_blk <= bus.proc_addr[29:2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_idle_hit && bus.proc_write) r_dirty[w_idx] <= 1'b1;
        end
        S_WRITEBACK: begin
          if (bus.mem_ready) r_dirty[w_miss_idx] <= 1'b0;
        end
        S_ALLOCATE: begin
          if (bus.mem_ready) begin
            r_valid[w_miss_idx] <= 1'b1;
            r_dirty[w_miss_idx] <= 1'b0;
          end
        end
        default: begin
          r_valid <= r_valid;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (w_idle_hit && bus.proc_write) begin
      r_data[w_idx][{w_off, 5'd0} +: 32] <= bus.proc_wdata;
    end else if ((r_state == S_ALLOCATE) && bus.mem_ready) begin
      r_data[w_miss_idx] <= bus.mem_rdata;
      r_tag[w_miss_idx]  <= r_miss_blk[27:INDEX_W];
    end
  end

endmodule

// File: tb/tb_dcache_direct_wb.sv
// Randomized scoreboard bench for dcache_direct_wb: a flat-memory reference
// predicts load data and the exact sequence of block write-backs and fills.
module tb_dcache_direct_wb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_direct_wb_if bus ();

  dcache_direct_wb #(.INDEX_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          chk_rd;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] data;
  } mtx_t;

  int n_checks = 0;
  int n_fail   = 0;

  resp_t resp_q[$];
  mtx_t  mtx_q[$];

  logic [127:0] mem    [logic [27:0]];
  logic [31:0]  ref_wr [logic [29:0]];
  bit           res_valid [8];
  bit           res_dirty [8];
  logic [27:0]  res_blk   [8];

  int lat_fixed = 0;
  bit noise_en  = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing store content for blocks never written.
  function automatic logic [127:0] mem_blk(input logic [27:0] b);
    logic [127:0] v;
    if (mem.exists(b)) return mem[b];
    for (int i = 0; i < 4; i++) v[i*32 +: 32] = {b[23:0], 6'd0, 2'(i)} ^ 32'hA500_0000;
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input logic [29:0] a);
    logic [127:0] blk;
    int w;
    if (ref_wr.exists(a)) return ref_wr[a];
    blk = mem_blk(a[29:2]);
    w = int'(a[1:0]);
    return blk[w*32 +: 32];
  endfunction

  function automatic bit model_req(input bit rd, input bit wr, input logic [29:0] a,
                                   input logic [31:0] wd, input bit push_resp);
    int          idx;
    logic [27:0] b;
    bit          miss;
    mtx_t        t;
    resp_t       r;
    idx  = int'(a[4:2]);
    b    = a[29:2];
    miss = !(res_valid[idx] && res_blk[idx] == b);
    if (miss) begin
      if (res_valid[idx] && res_dirty[idx]) begin
        t.wr   = 1'b1;
        t.addr = res_blk[idx];
        for (int i = 0; i < 4; i++) t.data[i*32 +: 32] = ref_word({res_blk[idx], 2'(i)});
        mtx_q.push_back(t);
      end
      t.wr   = 1'b0;
      t.addr = b;
      t.data = '0;
      mtx_q.push_back(t);
      res_valid[idx] = 1'b1;
      res_blk[idx]   = b;
      res_dirty[idx] = 1'b0;
    end
    r.chk_rd = 1'b0;
    r.data   = '0;
    if (wr) begin
      ref_wr[a]      = wd;
      res_dirty[idx] = 1'b1;
    end else if (rd) begin
      r.chk_rd = 1'b1;
      r.data   = ref_word(a);
    end
    if (push_resp) resp_q.push_back(r);
    return miss;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      res_valid[i] = 1'b0;
      res_dirty[i] = 1'b0;
    end
    ref_wr.delete();
    mtx_q.delete();
  endfunction

  task automatic do_req(input bit rd, input bit wr, input logic [29:0] a,
                        input logic [31:0] wd, output int stalls);
    bit miss;
    @(posedge clk); #1;
    bus.proc_read  = rd;
    bus.proc_write = wr;
    bus.proc_addr  = a;
    bus.proc_wdata = wd;
    miss   = model_req(rd, wr, a, wd, 1'b1);
    stalls = 0;
    @(negedge clk);
    check("first_cycle_stall", bus.proc_stall, miss);
    while (bus.proc_stall) begin
      stalls++;
      if (stalls > 60) begin
        n_checks++;
        n_fail++;
        $display("FAIL req_timeout: addr %h still stalled after %0d cycles", a, stalls);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
  endtask

  // Response monitor: pops one expectation per serviced request.
  resp_t mon_r;
  always @(negedge clk) begin
    if (rst_n && (bus.proc_read || bus.proc_write) && !bus.proc_stall) begin
      if (resp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL resp_unexpected: serviced addr %h with nothing expected", bus.proc_addr);
      end else begin
        mon_r = resp_q.pop_front();
        if (mon_r.chk_rd) check("load_data", bus.proc_rdata, mon_r.data);
      end
    end
  end

  // Memory responder and block-transaction monitor.
  bit   rsp_active = 1'b0;
  int   rsp_cnt;
  int   rsp_lat;
  mtx_t rsp_t;
  always begin
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    if (bus.mem_read && bus.mem_write) begin
      n_checks++;
      n_fail++;
      $display("FAIL mem_rw_both: mem_read and mem_write both high");
    end
    if (bus.mem_read || bus.mem_write) begin
      if (!rsp_active) begin
        rsp_active = 1'b1;
        rsp_cnt    = 0;
        rsp_lat    = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
        if (mtx_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL mem_unexpected: write=%0b addr %h", bus.mem_write, bus.mem_addr);
          rsp_t.wr   = bus.mem_write;
          rsp_t.addr = bus.mem_addr;
          rsp_t.data = bus.mem_wdata;
        end else begin
          rsp_t = mtx_q.pop_front();
        end
      end
      check("mem_is_write", bus.mem_write, rsp_t.wr);
      check("mem_addr", bus.mem_addr, rsp_t.addr);
      if (rsp_t.wr) check("mem_wdata", bus.mem_wdata, rsp_t.data);
      rsp_cnt++;
      if (rsp_cnt >= rsp_lat) begin
        bus.mem_ready = 1'b1;
        if (bus.mem_write) mem[bus.mem_addr] = bus.mem_wdata;
        else               bus.mem_rdata = mem_blk(bus.mem_addr);
        rsp_active = 1'b0;
      end
    end else begin
      rsp_active = 1'b0;
      if (noise_en) begin
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st;
    int          op;
    int          waitc;
    logic [29:0] a;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = '0;
    model_reset();
    mem[28'h4] = 128'h00000004_00000003_00000002_00000001;

    #12;
    check("rst_stall", bus.proc_stall, 1'b0);
    check("rst_rdata", bus.proc_rdata, 32'h0);
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_mem_write", bus.mem_write, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 28'h0);
    check("rst_mem_wdata", bus.mem_wdata, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (12) begin
      @(negedge clk);
      check("idle_stall", bus.proc_stall, 1'b0);
      check("idle_mem_read", bus.mem_read, 1'b0);
      check("idle_mem_write", bus.mem_write, 1'b0);
    end

    lat_fixed = 3;
    do_req(1, 0, 30'h10, 32'h0, st);
    check("cold_miss_stall_cycles", st, 4);
    do_req(1, 0, 30'h13, 32'h0, st);
    check("hit_no_stall", st, 0);
    do_req(0, 1, 30'h11, 32'hDEADBEEF, st);
    check("store_hit_no_stall", st, 0);
    do_req(1, 0, 30'h11, 32'h0, st);
    do_req(1, 0, 30'h10, 32'h0, st);
    do_req(1, 0, 30'h12, 32'h0, st);
    do_req(1, 0, 30'h13, 32'h0, st);
    do_req(1, 0, 30'h30, 32'h0, st);
    check("dirty_miss_stall_cycles", st, 7);
    do_req(0, 1, 30'h22, 32'hCAFE0022, st);
    do_req(1, 1, 30'h23, 32'h12345678, st);
    do_req(1, 0, 30'h42, 32'h0, st);
    do_req(1, 0, 30'h20, 32'h0, st);

    // Reset in the middle of a fill.
    lat_fixed = 10;
    @(posedge clk); #1;
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h50;
    void'(model_req(1, 0, 30'h50, 32'h0, 1'b0));
    waitc = 0;
    @(negedge clk);
    while (!bus.mem_read && waitc < 20) begin
      waitc++;
      @(negedge clk);
    end
    check("alloc_reached", bus.mem_read, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_read", bus.mem_read, 1'b0);
    check("async_rst_mem_write", bus.mem_write, 1'b0);
    check("async_rst_stall", bus.proc_stall, 1'b0);
    model_reset();
    @(posedge clk); #1;
    bus.proc_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lat_fixed = 3;
    do_req(1, 0, 30'h10, 32'h0, st);
    check("post_reset_miss", st, 4);
    do_req(1, 0, 30'h11, 32'h0, st);

    // Request dropped after its first cycle still completes the fill.
    @(posedge clk); #1;
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h1C;
    void'(model_req(1, 0, 30'h1C, 32'h0, 1'b0));
    @(posedge clk); #1;
    bus.proc_read = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("drop_fill_done", bus.mem_read, 1'b0);
    do_req(1, 0, 30'h1D, 32'h0, st);
    check("drop_then_hit", st, 0);

    lat_fixed = 0;
    for (int n = 0; n < 400; n++) begin
      a  = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      op = int'($urandom_range(0, 9));
      if (op < 5)      do_req(1, 0, a, 32'h0, st);
      else if (op < 9) do_req(0, 1, a, $urandom, st);
      else             do_req(1, 1, a, $urandom, st);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    check("resp_q_drained", resp_q.size(), 0);
    check("mtx_q_drained", mtx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
